// File: rtl/pll_reset_seq.sv
// Reset sequencer for the pixel and draw domains, driven by the PLL lock.
// The resets release only after the PLL has been locked for a set time. The
// draw domain releases a fixed number of cycles after the pixel domain.
// Losing lock while running reasserts both resets at once and is counted.
module pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int DRAW_STAGGER       = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk_pix,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  clr_lost,
    output logic                  rst_pix_out,
    output logic                  rst_draw_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int STAG_W = (DRAW_STAGGER > 0) ? $clog2(DRAW_STAGGER + 1) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_END  = STAG_W'(DRAW_STAGGER);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [STAB_W-1:0]       stab_cnt_q, stab_cnt_d;
    logic [STAG_W-1:0]       stag_cnt_q, stag_cnt_d;
    logic                    lock_lost_q, lock_lost_d;
    logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
    logic                    locked_s;
    logic                    loss_evt;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state logic for the lock qualification FSM, counters and debug flags.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], locked};
        state_d     = state_q;
        stab_cnt_d  = stab_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        lock_lost_d = lock_lost_q;
        loss_cnt_d  = loss_cnt_q;
        loss_evt    = 1'b0;

        case (state_q)
            ST_WAIT: begin
                stab_cnt_d = '0;
                if (locked_s) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                // A dropout here only restarts qualification; it is not a loss.
                if (!locked_s) begin
                    state_d = ST_WAIT;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = ST_RUN;
                    stag_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT;
                    loss_evt = 1'b1;
                end else if (stag_cnt_q != STAG_END) begin
                    stag_cnt_d = stag_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // A clear that coincides with a new loss loses to the set.
        if (clr_lost) begin
            lock_lost_d = 1'b0;
        end
        if (loss_evt) begin
            lock_lost_d = 1'b1;
            if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
                loss_cnt_d = loss_cnt_q + 1'b1;
            end
        end
    end

    // State, synchronizer and counter registers with synchronous reset.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            sync_q      <= '0;
            stab_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            stab_cnt_q  <= stab_cnt_d;
            stag_cnt_q  <= stag_cnt_d;
            lock_lost_q <= lock_lost_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        rst_pix_out  = (state_q != ST_RUN);
        rst_draw_out = (state_q != ST_RUN) || (stag_cnt_q < STAG_END);
        ready        = !rst_draw_out;
        lock_lost    = lock_lost_q;
        loss_cnt     = loss_cnt_q;
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq. The main instance uses short qualification
// and a 2-bit loss counter. A second instance uses the minimum qualification
// and no stagger, and shares the same inputs.
module tb_pll_reset_seq;

    logic       clk_pix = 1'b0;
    logic       rst;
    logic       locked;
    logic       clr_lost;
    logic       pix, draw, rdy, lost;
    logic [1:0] cnt;
    logic       pix0, draw0, rdy0, lost0;
    logic [7:0] cnt0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_pix = ~clk_pix;

    pll_reset_seq #(
        .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8), .DRAW_STAGGER(4), .LOSS_CNT_W(2)
    ) u_dut (
        .clk_pix(clk_pix), .rst(rst), .locked(locked), .clr_lost(clr_lost),
        .rst_pix_out(pix), .rst_draw_out(draw), .ready(rdy),
        .lock_lost(lost), .loss_cnt(cnt)
    );

    pll_reset_seq #(
        .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(1), .DRAW_STAGGER(0), .LOSS_CNT_W(8)
    ) u_dut0 (
        .clk_pix(clk_pix), .rst(rst), .locked(locked), .clr_lost(clr_lost),
        .rst_pix_out(pix0), .rst_draw_out(draw0), .ready(rdy0),
        .lock_lost(lost0), .loss_cnt(cnt0)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_pix);
        #1;
    endtask

    initial begin
        rst = 1'b1; locked = 1'b0; clr_lost = 1'b0;
        step(3);
        chk("rst_pix",  int'(pix),  1);
        chk("rst_draw", int'(draw), 1);
        chk("rst_rdy",  int'(rdy),  0);
        chk("rst_lost", int'(lost), 0);
        chk("rst_cnt",  int'(cnt),  0);
        rst = 1'b0;
        step(2);

        // Clean lock-up: locked rises just after edge 0.
        locked = 1'b1;
        step(3);
        chk("up0_pix_e3", int'(pix0), 1);
        step(1);
        chk("up0_pix_e4",  int'(pix0),  0);
        chk("up0_draw_e4", int'(draw0), 0);
        chk("up0_rdy_e4",  int'(rdy0),  1);
        step(6);
        chk("up_pix_e10",  int'(pix),  1);
        chk("up_draw_e10", int'(draw), 1);
        step(1);
        chk("up_pix_e11",  int'(pix),  0);
        chk("up_draw_e11", int'(draw), 1);
        chk("up_rdy_e11",  int'(rdy),  0);
        step(3);
        chk("up_draw_e14", int'(draw), 1);
        step(1);
        chk("up_draw_e15", int'(draw), 0);
        chk("up_rdy_e15",  int'(rdy),  1);
        chk("up_cnt",      int'(cnt),  0);
        chk("up_lost",     int'(lost), 0);

        // Loss in RUN: both resets rise 3 edges after locked falls.
        locked = 1'b0;
        step(2);
        chk("loss_pix_j2", int'(pix),  0);
        chk("loss_rdy_j2", int'(rdy),  1);
        chk("loss0_pix_j2", int'(pix0), 0);
        step(1);
        chk("loss_pix_j3",  int'(pix),  1);
        chk("loss_draw_j3", int'(draw), 1);
        chk("loss_rdy_j3",  int'(rdy),  0);
        chk("loss_cnt",     int'(cnt),  1);
        chk("loss_lost",    int'(lost), 1);
        chk("loss0_pix_j3",  int'(pix0),  1);
        chk("loss0_draw_j3", int'(draw0), 1);
        chk("loss0_cnt",     int'(cnt0),  1);
        chk("loss0_lost",    int'(lost0), 1);
        locked = 1'b1;
        step(10);
        chk("relock_pix_e10", int'(pix), 1);
        step(1);
        chk("relock_pix_e11", int'(pix), 0);
        step(4);
        chk("relock_rdy", int'(rdy), 1);

        // Clear alone.
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        chk("clr_lost", int'(lost), 0);
        chk("clr_cnt",  int'(cnt),  1);

        // Second loss, then clear, then a glitch during qualification.
        locked = 1'b0;
        step(3);
        chk("loss2_cnt", int'(cnt), 2);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        locked = 1'b1;
        step(5);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(10);
        chk("glitch_pix_e10", int'(pix), 1);
        step(1);
        chk("glitch_pix_e11",  int'(pix),  0);
        chk("glitch_draw_e11", int'(draw), 1);
        step(4);
        chk("glitch_rdy",  int'(rdy),  1);
        chk("glitch_cnt",  int'(cnt),  2);
        chk("glitch_lost", int'(lost), 0);

        // Clear coincident with a loss event: the set wins.
        locked = 1'b0;
        step(2);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        chk("clrset_lost", int'(lost), 1);
        chk("clrset_cnt",  int'(cnt),  3);
        chk("clrset_pix",  int'(pix),  1);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        chk("clr2_lost", int'(lost), 0);
        chk("clr2_cnt",  int'(cnt),  3);

        // Reset while in STABLE.
        locked = 1'b1;
        step(5);
        rst = 1'b1;
        step(1);
        chk("mrst_s_pix",  int'(pix),  1);
        chk("mrst_s_draw", int'(draw), 1);
        chk("mrst_s_rdy",  int'(rdy),  0);
        chk("mrst_s_cnt",  int'(cnt),  0);
        chk("mrst_s_lost", int'(lost), 0);
        rst = 1'b0;
        step(10);
        chk("mrst_s_pix_e10", int'(pix), 1);
        step(1);
        chk("mrst_s_pix_e11", int'(pix), 0);
        step(4);
        chk("mrst_s_rdy_e15", int'(rdy), 1);

        // Reset while in RUN.
        rst = 1'b1;
        step(1);
        chk("mrst_r_pix",  int'(pix),  1);
        chk("mrst_r_draw", int'(draw), 1);
        chk("mrst_r_rdy",  int'(rdy),  0);
        chk("mrst_r_cnt",  int'(cnt),  0);
        rst = 1'b0;
        step(10);
        chk("mrst_r_pix_e10", int'(pix), 1);
        step(1);
        chk("mrst_r_pix_e11",  int'(pix),  0);
        chk("mrst_r_draw_e11", int'(draw), 1);
        step(4);
        chk("mrst_r_draw_e15", int'(draw), 0);
        chk("mrst_r_rdy_e15",  int'(rdy),  1);

        // Saturating loss counter: 1, 2, 3, 3, 3.
        for (int i = 0; i < 5; i++) begin
            locked = 1'b0;
            step(3);
            chk($sformatf("sat_cnt_%0d", i), int'(cnt), (i < 2) ? i + 1 : 3);
            chk($sformatf("sat_pix_%0d", i), int'(pix), 1);
            locked = 1'b1;
            step(12);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
